rs232_host: RTL and testbench

- Serial command master: the initiator end of the local I/O device interface, driving it from an RS232 link.
- Receives 8N1 command bytes on RxD, issues one read or write to a local I/O device, and returns an ack byte or read data on TxD.
- Sits between a board UART pin pair and any single local I/O device (debug/bring-up bridge).

---
 rtl/rs232_host_pkg.sv | 29 ++
 rtl/rs232_host_rx.sv | 102 ++++++++++
 rtl/rs232_host.sv | 216 +++++++++++++++++++++
 tb/tb_rs232_host.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rs232_host_pkg.sv
// Shared constants and state encodings for the rs232_host serial command master.
package rs232_host_pkg;

  localparam logic [7:0] OP_READ    = 8'h52;
  localparam logic [7:0] OP_READ_A3 = 8'h72;
  localparam logic [7:0] OP_WRITE   = 8'h57;

  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;
  localparam logic [7:0] TMO = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_LO,
    ST_GET_HI,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_SEND
  } host_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

endpackage

// File: rtl/rs232_host_rx.sv
// 8N1 deserializer: mid-bit sampling, one-cycle byte strobe, framing-error pulse.
module rs232_host_rx
  import rs232_host_pkg::*;
#(
  parameter int bitTime = 868
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rxd_i,
  output logic [7:0] data_o,
  output logic       strobe_o,
  output logic       frame_err_o
);

  localparam int CW = $clog2(bitTime + 1);

  rx_state_e     state_q, state_d;
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bits_q, bits_d;
  logic [7:0]    shift_q, shift_d;
  logic          strobe_q, strobe_d;
  logic          ferr_q, ferr_d;
  logic          rx;

  assign rx          = sync_q[1];
  assign data_o      = shift_q;
  assign strobe_o    = strobe_q;
  assign frame_err_o = ferr_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bits_d   = bits_q;
    shift_d  = shift_q;
    strobe_d = 1'b0;
    ferr_d   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rx) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == CW'(bitTime / 2 - 1)) begin
          cnt_d   = '0;
          bits_d  = '0;
          state_d = rx ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == CW'(bitTime - 1)) begin
          cnt_d   = '0;
          shift_d = {rx, shift_q[7:1]};
          bits_d  = bits_q + 3'd1;
          if (bits_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == CW'(bitTime - 1)) begin
          cnt_d = '0;
          if (rx) begin
            strobe_d = 1'b1;
            state_d  = RX_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = RX_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      // A low stop bit may be a break; resync only once the line is idle again.
      RX_BREAK: if (rx) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= RX_IDLE;
      sync_q   <= 2'b11;
      cnt_q    <= '0;
      bits_q   <= '0;
      shift_q  <= '0;
      strobe_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= {sync_q[0], rxd_i};
      cnt_q    <= cnt_d;
      bits_q   <= bits_d;
      shift_q  <= shift_d;
      strobe_q <= strobe_d;
      ferr_q   <= ferr_d;
    end
  end

endmodule

// File: rtl/rs232_host.sv
// RS232-to-local-I/O command bridge: parser FSM, device handshake and 8N1 transmitter.
// RS232_HOST_TIMEOUT_EN adds a done-wait watchdog that answers 0xEE.
module rs232_host
  import rs232_host_pkg::*;
#(
  parameter int bitTime       = 868,
  parameter int timeoutCycles = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        RxD,
  output logic        TxD,
  output logic        sel,
  output logic        read,
  output logic        a3,
  output logic [9:0]  wq,
  input  logic        rwq,
  input  logic [31:0] rq,
  input  logic        wrq,
  input  logic        done
);

  localparam int CW = $clog2(bitTime + 1);

  host_state_e   state_q, state_d;
  logic          sel_q, sel_d, read_q, read_d, a3_q, a3_d;
  logic [9:0]    wq_q, wq_d;
  logic [7:0]    lo_q, lo_d;
  logic [31:0]   data_q, data_d, resp_q, resp_d;
  logic [2:0]    nbytes_q, nbytes_d;
  logic          txd_q, txd_d, txact_q, txact_d, tx_load;
  logic [8:0]    frame_q, frame_d;
  logic [3:0]    bidx_q, bidx_d;
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic [7:0]    rx_byte;
  logic          rx_stb, rx_ferr;
  logic          unused_ok;

`ifdef RS232_HOST_TIMEOUT_EN
  localparam int TW = $clog2(timeoutCycles + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  // The device's consume strobe is informational only.
  assign unused_ok = &{1'b0, rwq, timeoutCycles > 0};

  assign TxD  = txd_q;
  assign sel  = sel_q;
  assign read = read_q;
  assign a3   = a3_q;
  assign wq   = wq_q;

  rs232_host_rx #(.bitTime(bitTime)) u_rx (
    .clock       (clock),
    .reset       (reset),
    .rxd_i       (RxD),
    .data_o      (rx_byte),
    .strobe_o    (rx_stb),
    .frame_err_o (rx_ferr)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    read_d   = read_q;
    a3_d     = a3_q;
    wq_d     = wq_q;
    lo_d     = lo_q;
    data_d   = data_q;
    resp_d   = resp_q;
    nbytes_d = nbytes_q;
    txd_d    = txd_q;
    txact_d  = txact_q;
    frame_d  = frame_q;
    bidx_d   = bidx_q;
    tcnt_d   = tcnt_q;
    tx_load  = 1'b0;
`ifdef RS232_HOST_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rx_stb) begin
          if (rx_byte == OP_READ || rx_byte == OP_READ_A3) begin
            sel_d   = 1'b1;
            read_d  = 1'b1;
            a3_d    = (rx_byte == OP_READ_A3);
            wq_d    = '0;
            state_d = ST_ISSUE;
          end else if (rx_byte == OP_WRITE) begin
            state_d = ST_GET_LO;
          end else begin
            resp_d   = {24'h0, NAK};
            nbytes_d = 3'd1;
            state_d  = ST_SEND;
          end
        end
      end
      ST_GET_LO: begin
        if (rx_ferr) state_d = ST_IDLE;
        else if (rx_stb) begin
          lo_d    = rx_byte;
          state_d = ST_GET_HI;
        end
      end
      ST_GET_HI: begin
        if (rx_ferr) state_d = ST_IDLE;
        else if (rx_stb) begin
          sel_d   = 1'b1;
          read_d  = 1'b0;
          a3_d    = 1'b0;
          wq_d    = {rx_byte[1:0], lo_q};
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        data_d  = '0;
        state_d = ST_WAIT_DONE;
`ifdef RS232_HOST_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      ST_WAIT_DONE: begin
        if (wrq) data_d = rq;
        if (done) begin
          sel_d    = 1'b0;
          resp_d   = read_q ? (wrq ? rq : data_q) : {24'h0, ACK};
          nbytes_d = read_q ? 3'd4 : 3'd1;
          state_d  = ST_SEND;
        end
`ifdef RS232_HOST_TIMEOUT_EN
        else if (tmo_q == TW'(timeoutCycles - 1)) begin
          sel_d    = 1'b0;
          resp_d   = {24'h0, TMO};
          nbytes_d = 3'd1;
          state_d  = ST_SEND;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
`endif
      end
      ST_SEND: begin
        if (!txact_q) begin
          tx_load = 1'b1;
        end else if (tcnt_q == CW'(bitTime - 1)) begin
          tcnt_d = '0;
          if (bidx_q == 4'd9) begin
            // Stop bit finished: chain the next byte with no idle gap.
            if (nbytes_q != 3'd0) tx_load = 1'b1;
            else begin
              txact_d = 1'b0;
              state_d = ST_IDLE;
            end
          end else begin
            txd_d   = frame_q[0];
            frame_d = {1'b0, frame_q[8:1]};
            bidx_d  = bidx_q + 4'd1;
          end
        end else begin
          tcnt_d = tcnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (tx_load) begin
      txact_d  = 1'b1;
      txd_d    = 1'b0;
      frame_d  = {1'b1, resp_q[7:0]};
      resp_d   = {8'h00, resp_q[31:8]};
      nbytes_d = nbytes_q - 3'd1;
      bidx_d   = '0;
      tcnt_d   = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      sel_q    <= 1'b0;
      read_q   <= 1'b0;
      a3_q     <= 1'b0;
      wq_q     <= '0;
      lo_q     <= '0;
      data_q   <= '0;
      resp_q   <= '0;
      nbytes_q <= '0;
      txd_q    <= 1'b1;
      txact_q  <= 1'b0;
      frame_q  <= '1;
      bidx_q   <= '0;
      tcnt_q   <= '0;
`ifdef RS232_HOST_TIMEOUT_EN
      tmo_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      read_q   <= read_d;
      a3_q     <= a3_d;
      wq_q     <= wq_d;
      lo_q     <= lo_d;
      data_q   <= data_d;
      resp_q   <= resp_d;
      nbytes_q <= nbytes_d;
      txd_q    <= txd_d;
      txact_q  <= txact_d;
      frame_q  <= frame_d;
      bidx_q   <= bidx_d;
      tcnt_q   <= tcnt_d;
`ifdef RS232_HOST_TIMEOUT_EN
      tmo_q    <= tmo_d;
`endif
    end
  end

endmodule

// File: tb/tb_rs232_host.sv
// Randomized bench for rs232_host: serial command driver, device model and TxD decoder.
module tb_rs232_host;

  localparam int BT = 16;
  localparam int K_READ = 0, K_WRITE = 1, K_BAD = 2, K_FERR = 3, K_FERR_LO = 4, K_TMO = 5;

  logic        clock = 1'b0;
  logic        reset, RxD, rwq, wrq, done;
  logic [31:0] rq;
  logic        TxD, sel, read, a3;
  logic [9:0]  wq;

  always #5 clock = ~clock;

  rs232_host #(.bitTime(BT), .timeoutCycles(64)) dut (
    .clock (clock), .reset (reset), .RxD (RxD), .TxD (TxD),
    .sel (sel), .read (read), .a3 (a3), .wq (wq),
    .rwq (rwq), .rq (rq), .wrq (wrq), .done (done)
  );

  int n_cmp = 0, n_bad = 0;
  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    RxD = 1'b0; tick(BT);
    for (int i = 0; i < 8; i++) begin RxD = b[i]; tick(BT); end
    RxD = stop; tick(BT);
    RxD = 1'b1;
  endtask

  // TxD decoder: frames are {stop, data} with the start-detect cycle alongside.
  logic [8:0]  mon_q[$];
  int unsigned mon_t[$];
  initial begin : tx_mon
    logic [8:0]  fr;
    int unsigned t0;
    forever begin
      @(posedge clock); #1;
      if (reset === 1'b0 && TxD === 1'b0) begin
        t0 = cyc;
        tick(BT / 2);
        if (TxD === 1'b0) begin
          for (int i = 0; i < 8; i++) begin tick(BT); fr[i] = TxD; end
          tick(BT); fr[8] = TxD;
          mon_q.push_back(fr);
          mon_t.push_back(t0);
        end
      end
    end
  end

  // Local I/O device model, configured per transaction by the main sequence.
  int          dev_delay = 5, dev_mode = 0, dev_early = 0, dev_nodone = 0;
  logic [31:0] dev_rq = '0;
  int          sel_windows = 0, sel_len = 0;
  logic        cap_read, cap_a3;
  logic [9:0]  cap_wq;
  bit          stable_ok;
  initial begin : device
    int k;
    k = 0; done = 0; wrq = 0; rwq = 0; rq = '0;
    forever begin
      @(posedge clock); #1;
      done = 1'b0; wrq = 1'b0; rwq = 1'b0; rq = $urandom;
      if (sel === 1'b1) begin
        if (k == 0) begin
          sel_windows++;
          cap_read = read; cap_a3 = a3; cap_wq = wq; stable_ok = 1'b1;
          if (dev_early != 0) done = 1'b1;
        end else if (read !== cap_read || a3 !== cap_a3 || wq !== cap_wq) begin
          stable_ok = 1'b0;
        end
        if (dev_mode == 2 && k == 1) begin wrq = 1'b1; rq = ~dev_rq; end
        if (dev_mode != 0 && k == dev_delay) begin wrq = 1'b1; rq = dev_rq; end
        if (dev_nodone == 0 && k == dev_delay) done = 1'b1;
        rwq = (k == 1);
        k++;
        sel_len = k;
      end else begin
        k = 0;
      end
    end
  end

  task automatic run_op(input int kind, input logic [7:0] opb, input logic [7:0] lo,
                        input logic [7:0] hi, input logic [31:0] rqv, input int mode,
                        input int dly, input int early);
    logic [7:0]  exp_b[$];
    bit          exp_sel;
    logic        exp_rd, exp_a3;
    logic [9:0]  exp_wq;
    logic [31:0] v;
    int          budget;
    mon_q.delete(); mon_t.delete();
    sel_windows = 0;
    dev_delay = dly; dev_mode = mode; dev_early = early; dev_rq = rqv;
    dev_nodone = (kind == K_TMO);
    exp_sel = 0; exp_rd = 0; exp_a3 = 0; exp_wq = '0;
    case (kind)
      K_READ, K_TMO: begin
        exp_sel = 1; exp_rd = 1; exp_a3 = (opb == 8'h72);
        if (kind == K_TMO) exp_b.push_back(8'hEE);
        else begin
          v = (mode == 0) ? 32'h0 : rqv;
          for (int i = 0; i < 4; i++) exp_b.push_back(v[8*i +: 8]);
        end
        send_byte(opb, 1'b1);
      end
      K_WRITE: begin
        exp_sel = 1; exp_wq = {hi[1:0], lo};
        exp_b.push_back(8'h06);
        send_byte(8'h57, 1'b1); send_byte(lo, 1'b1); send_byte(hi, 1'b1);
      end
      K_BAD: begin
        exp_b.push_back(8'h15);
        send_byte(opb, 1'b1);
      end
      K_FERR: send_byte(opb, 1'b0);
      default: begin
        send_byte(8'h57, 1'b1); send_byte(lo, 1'b0);
      end
    endcase
    budget = 0;
    while (mon_q.size() < exp_b.size() && budget < 1500) begin tick(1); budget++; end
    tick(12 * BT);
    check_val("resp_count", mon_q.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < mon_q.size(); i++) begin
      check_val($sformatf("resp_byte%0d", i), mon_q[i][7:0], exp_b[i]);
      check_val($sformatf("resp_stop%0d", i), mon_q[i][8], 1'b1);
    end
    if (kind == K_READ && mon_q.size() == 4)
      for (int i = 1; i < 4; i++)
        check_val($sformatf("b2b_gap%0d", i), mon_t[i] - mon_t[i-1], 10 * BT);
    check_val("sel_windows", sel_windows, exp_sel);
    if (exp_sel && sel_windows == 1) begin
      check_val("read", cap_read, exp_rd);
      check_val("a3", cap_a3, exp_a3);
      if (kind == K_WRITE) check_val("wq", cap_wq, exp_wq);
      check_val("sel_stable", stable_ok, 1'b1);
      if (kind == K_TMO) check_val("tmo_len", (sel_len >= 64 && sel_len <= 66), 1'b1);
      else check_val("sel_len", sel_len, dly + 1);
    end
    $display("op kind=%0d opb=%02h lo=%02h hi=%02h mode=%0d dly=%0d early=%0d -> %0d resp bytes, %0d sel windows",
             kind, opb, lo, hi, mode, dly, early, mon_q.size(), sel_windows);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin : main
    int          kind, budget;
    logic [7:0]  b;
    RxD = 1'b1; reset = 1'b1;
    tick(5);
    check_val("rst_sel", sel, 1'b0);
    check_val("rst_read", read, 1'b0);
    check_val("rst_a3", a3, 1'b0);
    check_val("rst_wq", wq, 10'h0);
    check_val("rst_txd", TxD, 1'b1);
    reset = 1'b0;
    tick(10);

    run_op(K_WRITE, 8'h57, 8'h41, 8'h03, 32'h0, 0, 5, 0);
    run_op(K_READ, 8'h72, 8'h00, 8'h00, 32'h12345678, 1, 5, 0);
    run_op(K_BAD, 8'h00, 8'h00, 8'h00, 32'h0, 0, 5, 0);
    run_op(K_READ, 8'h52, 8'h00, 8'h00, 32'hCAFEF00D, 2, 4, 1);
    run_op(K_FERR, 8'h57, 8'h00, 8'h00, 32'h0, 0, 5, 0);
    run_op(K_READ, 8'h52, 8'h00, 8'h00, 32'h0BADBEEF, 0, 3, 0);

    // Reset while the second byte of a read response is on the wire.
    mon_q.delete(); mon_t.delete();
    dev_delay = 4; dev_mode = 1; dev_early = 0; dev_nodone = 0; dev_rq = 32'h12345678;
    send_byte(8'h52, 1'b1);
    budget = 0;
    while (mon_q.size() < 1 && budget < 1500) begin tick(1); budget++; end
    check_val("mid_first_byte", mon_q.size(), 1);
    budget = 0;
    while (TxD !== 1'b0 && budget < 100) begin tick(1); budget++; end
    check_val("mid_second_start", TxD, 1'b0);
    reset = 1'b1;
    tick(1);
    check_val("mid_rst_txd", TxD, 1'b1);
    check_val("mid_rst_sel", sel, 1'b0);
    tick(2);
    reset = 1'b0;
    tick(12 * BT);
    check_val("mid_rst_quiet", mon_q.size(), 1);
    $display("op reset during read response -> txd=%0b sel=%0b", TxD, sel);
    run_op(K_READ, 8'h52, 8'h00, 8'h00, 32'hA5A55A5A, 1, 6, 0);

`ifdef RS232_HOST_TIMEOUT_EN
    run_op(K_TMO, 8'h52, 8'h00, 8'h00, 32'h0, 0, 5, 0);
    run_op(K_READ, 8'h72, 8'h00, 8'h00, 32'h01020304, 1, 5, 0);
`endif

    for (int n = 0; n < 20; n++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        K_READ:  b = ($urandom_range(0, 1) != 0) ? 8'h72 : 8'h52;
        K_BAD: begin
          b = 8'($urandom);
          while (b == 8'h52 || b == 8'h72 || b == 8'h57) b = 8'($urandom);
        end
        default: b = 8'($urandom);
      endcase
      run_op(kind, b, 8'($urandom), 8'($urandom), $urandom, $urandom_range(0, 2),
             $urandom_range(2, 8), $urandom_range(0, 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
